// File: rtl/layer_sequencer.sv
// Layer sequencer: walks one fully connected layer through a single MAC, one
// neuron at a time, and assembles the activated 16-bit results into layer_out.
module layer_sequencer #(
  parameter int N_NEURONS = 4,
  parameter int N_INPUTS  = 12,
  parameter int BASE_ADDR = 0,
  parameter int N         = 16,
  parameter int Q         = 12,
  parameter int RELU      = 1,
  parameter int TIMEOUT   = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    layer_start,
  output logic                    mac_run,
  output logic signed [31:0]      mac_start,
  output logic signed [31:0]      mac_size,
  input  logic                    mac_done,
  input  logic [N-1:0]            mac_out,
  output logic [N_NEURONS*N-1:0]  layer_out,
  output logic                    busy,
  output logic                    layer_done,
  output logic                    timeout_err
);

  localparam int KW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  if (N_NEURONS < 1 || N_NEURONS > 64 || Q >= N) begin : g_param_err
    $error("layer_sequencer: illegal parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_ARM, S_RUN, S_CAPTURE, S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [KW-1:0]           k_q, k_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic                    done_prev_q;
  logic                    mac_run_q, mac_run_d;
  logic signed [31:0]      mac_start_q, mac_start_d;
  logic [N_NEURONS*N-1:0]  layer_out_q, layer_out_d;
  logic                    busy_q, busy_d;
  logic                    layer_done_q, layer_done_d;
  logic                    timeout_err_q, timeout_err_d;
  logic                    done_rise_s;

  // Only a 0->1 transition counts; a done level left over from before RUN is stale.
  assign done_rise_s = mac_done & ~done_prev_q;

  // Next-state and next-output logic; outputs are derived from the next state so they register cleanly.
  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    timer_d       = timer_q;
    mac_start_d   = mac_start_q;
    layer_out_d   = layer_out_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      S_IDLE: begin
        if (layer_start) begin
          state_d       = S_ISSUE;
          k_d           = '0;
          timeout_err_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        mac_start_d = 32'(BASE_ADDR) + 32'(k_q) * 32'(N_INPUTS);
        timer_d     = '0;
        state_d     = S_ARM;
      end
      S_ARM: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        timer_d = timer_q + TW'(1);
        if (done_rise_s) begin
          state_d = S_CAPTURE;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          timeout_err_d = 1'b1;
          state_d       = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_CAPTURE: begin
        // Sign bit set (including negative zero) means negative for ReLU.
        if ((RELU != 0) && mac_out[N-1]) begin
          layer_out_d[k_q*N +: N] = '0;
        end else begin
          layer_out_d[k_q*N +: N] = mac_out;
        end
        if (k_q == KW'(N_NEURONS - 1)) begin
          state_d = S_DONE;
        end else begin
          k_d     = k_q + KW'(1);
          state_d = S_ISSUE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    mac_run_d    = (state_d == S_RUN);
    busy_d       = (state_d != S_IDLE);
    layer_done_d = (state_d == S_DONE);
  end

  // State and registered outputs; reset aborts any pass in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      k_q           <= '0;
      timer_q       <= '0;
      done_prev_q   <= 1'b0;
      mac_run_q     <= 1'b0;
      mac_start_q   <= 32'(BASE_ADDR);
      layer_out_q   <= '0;
      busy_q        <= 1'b0;
      layer_done_q  <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      timer_q       <= timer_d;
      done_prev_q   <= mac_done;
      mac_run_q     <= mac_run_d;
      mac_start_q   <= mac_start_d;
      layer_out_q   <= layer_out_d;
      busy_q        <= busy_d;
      layer_done_q  <= layer_done_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign mac_run     = mac_run_q;
  assign mac_start   = mac_start_q;
  assign mac_size    = 32'(N_INPUTS);
  assign layer_out   = layer_out_q;
  assign busy        = busy_q;
  assign layer_done  = layer_done_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
- Initiator side of the neuron MAC handshake (run / start / size in; done / out back).
- Steps one fully connected layer through N_NEURONS neurons. For each neuron it issues a weight window to the MAC, waits for completion, then captures, activates and stores the 16-bit fixed-point result.
- Sits between the network top-level controller and one MAC instance. It presents the finished layer vector to the next layer.

Parameters:
- N_NEURONS, 4, neurons in the layer (1..64)
- N_INPUTS, 12, inputs per neuron; driven as mac_size
- BASE_ADDR, 0, weight-memory address of neuron 0's first weight
- N, 16, word width
- Q, 12, fractional bits (format matches the MAC: sign-magnitude, MSB is sign)
- RELU, 1, 1 = apply ReLU to each captured result, 0 = pass through
- TIMEOUT, 1024, max cycles in RUN per neuron before an error is raised

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- layer_start  in  1  one-cycle pulse; starts a layer pass (ignored unless IDLE)
- mac_run  out  1  MAC enable; low clears the MAC index and accumulator
- mac_start  out  32 signed  first weight address for the current neuron
- mac_size  out  32 signed  weight count for the current neuron, always N_INPUTS
- mac_done  in  1  MAC completion level
- mac_out  in  N  MAC accumulated result
- layer_out  out  N_NEURONS*N  result vector; neuron k occupies bits [k*N +: N]
- busy  out  1  high from the cycle after layer_start until DONE exits
- layer_done  out  1  one-cycle pulse when all neurons are stored
- timeout_err  out  1  sticky; set on MAC timeout, cleared only by reset or by layer_start

Behaviour:
- Reset (async, rst_n=0) values: state=IDLE, mac_run=0, mac_start=BASE_ADDR, mac_size=N_INPUTS, layer_out=0, busy=0, layer_done=0, timeout_err=0, neuron index k=0, timer=0.
- Reset asserted mid-pass aborts immediately. No partial result is kept.
- States and transitions:
  - IDLE: layer_start=1 -> ISSUE; k<=0; timeout_err<=0.
  - ISSUE (1 cycle): mac_run=0; mac_start<=BASE_ADDR + k*N_INPUTS; timer<=0 -> ARM.
  - ARM (1 cycle): mac_run=0, start/size stable. Together with ISSUE this guarantees 2 low cycles so the MAC reloads its index from start -> RUN.
  - RUN: mac_run=1; timer increments each cycle.
    - Rising edge of mac_done (registered previous value 0, current 1) -> CAPTURE.
    - timer==TIMEOUT-1 without that edge -> timeout_err<=1 -> DONE.
    - An edge and the timeout in the same cycle -> CAPTURE takes priority; no error.
  - CAPTURE (1 cycle): mac_run<=0.
    - Slot k <= (RELU && mac_out[N-1]) ? 0 : mac_out.
    - Negative zero (0x8000) is treated as negative: stored as 0 with RELU=1, stored unchanged with RELU=0.
    - k==N_NEURONS-1 -> DONE; otherwise k<=k+1 -> ISSUE.
  - DONE (1 cycle): layer_done=1, mac_run=0 -> IDLE. busy falls on the cycle DONE exits.
- MAC contract: mac_done must be low while mac_run is low, or be treated as stale. Only a 0->1 transition observed while in RUN is accepted. A done already high on entry to RUN is ignored until it drops and rises again.
- layer_start while busy is ignored, with no effect on k or the outputs.
- layer_out slots not yet written in the current pass hold their values from the previous pass. On timeout, slots k..N_NEURONS-1 are left unchanged.
- Address arithmetic is 32-bit signed, with no overflow checking. mac_start is constant outside ISSUE.
- Per-neuron latency = 2 (ISSUE+ARM) + MAC cycles + 1 detect + 1 CAPTURE.
- Layer latency = N_NEURONS * per-neuron latency + 1.

Test Plan:
- Basic pass:
  - Stimulus: N_NEURONS=4, N_INPUTS=12, BASE_ADDR=0; MAC model raises done 48 cycles after run, returning 0x1000, 0x2800, 0x0400, 0x0000.
  - Required: mac_start sequence 0, 12, 24, 36; layer_out = {0x0000, 0x0400, 0x2800, 0x1000}; single layer_done pulse; busy low afterwards.
- ReLU:
  - Stimulus: results 0x9000, 0x8000, 0x7FFF, 0x0001 with RELU=1.
  - Required: slots 0x0000, 0x0000, 0x7FFF, 0x0001.
  - Same stimulus with RELU=0: slots hold the raw values.
- Stale done:
  - Stimulus: mac_done held high when RUN is entered, drops after 3 cycles, rises 10 cycles later.
  - Required: capture happens only on that later rise.
- Timeout:
  - Stimulus: TIMEOUT=64; MAC never asserts done on neuron 2.
  - Required: timeout_err=1 after 64 RUN cycles; layer_done pulses; slots 2-3 unchanged; the next layer_start clears timeout_err.
- Mid-pass controls:
  - Stimulus: layer_start pulsed during neuron 1.
  - Required: ignored; pass completes normally.
  - Stimulus: rst_n pulled low during RUN of neuron 2.
  - Required: all outputs return to reset values asynchronously; a new layer_start restarts from mac_start=BASE_ADDR.
- Edge count:
  - Stimulus: N_NEURONS=1, BASE_ADDR=100, done arriving simultaneously with the timeout cycle.
  - Required: mac_start=100; result captured; no error; layer_done after 1 neuron.
